frame_decode: RTL and testbench
===============================

# frame_decode

Byte-stream frame decoder that sits directly downstream of the serial `receive` stage. It consumes the receiver's per-byte strobe, data and framing-error outputs and hunts for a sync byte. It assembles an address byte plus a big-endian data word and verifies an XOR checksum. Each good frame is presented as one address/word pair on a valid/ready output port, which the host-side command logic consumes.

## Interface

- `BYTES`, default 2: number of data bytes per frame, range 1..4. Output word width is 8*BYTES.
- `SYNC`, default 8'hA5: frame start marker.

- `clk`  in  1  system clock (same clock as `receive`)
- `rst`  in  1  asynchronous, active-high reset
- `rx_stb`  in  1  one-cycle pulse: `rx_dat`/`rx_err` valid (from `receive`.stb)
- `rx_dat`  in  8  received byte (from `receive`.dat)
- `rx_err`  in  1  framing error for this byte, sampled only with `rx_stb`
- `out_stb`  out  1  frame valid; held until accepted
- `out_rdy`  in  1  consumer ready
- `out_adr`  out  8  frame address byte
- `out_dat`  out  8*BYTES  frame data word, first received byte in MSBs
- `bad`  out  1  one-cycle pulse: frame discarded (checksum mismatch or `rx_err`)
- `ovf`  out  1  one-cycle pulse: good frame dropped because output still pending

## Operation

- Frame format on the wire: SYNC, ADR, D[0]..D[BYTES-1], CHK. Here CHK = ADR ^ D[0] ^ … ^ D[BYTES-1]. SYNC is not included in the checksum.
- All state advances only on cycles with `rx_stb`=1. Bytes are never assumed back-to-back.
- FSM states:
  - HUNT: `rx_dat`==SYNC with no error -> ADDR. Any other byte is dropped silently, with no `bad`.
  - ADDR: latch the address into the shadow register and initialise the running XOR to the byte -> DATA, with counter=0.
  - DATA: shift the byte into the shadow word, XOR it into the running sum, increment the counter. After byte BYTES-1 -> CHECK.
  - CHECK: compare the byte with the running XOR.
    - Match: completion event -> HUNT.
    - Mismatch: pulse `bad` -> HUNT.
- `rx_err`=1 with `rx_stb` in any state other than HUNT:
  - discard the partial frame, pulse `bad`, -> HUNT.
  - The errored byte is never interpreted as SYNC.
- `rx_err` in HUNT: the byte is dropped, no `bad`.
- Only the byte following SYNC acts as the address. SYNC-valued bytes in ADR/DATA/CHK positions are ordinary data and do not resynchronise.
- Output register, on a completion event:
  - If `out_stb`=0, or `out_stb`&&`out_rdy` in the same cycle: load `out_adr`/`out_dat` from the shadow registers and set `out_stb`=1.
  - Otherwise drop the new frame, pulse `ovf`, and leave `out_adr`/`out_dat`/`out_stb` unchanged.
- Handshake:
  - A transfer occurs on any cycle with `out_stb`&&`out_rdy`.
  - `out_stb` clears on the next cycle unless a completion load occurs in that same cycle.
  - `out_adr`/`out_dat` are stable while `out_stb`=1 and not yet accepted.
- The running XOR and shadow word are cleared on entry to ADDR. Nothing carries over between frames.

## Timing

- Reset (async assert, released synchronously by the system reset logic): state HUNT, counter 0. `out_stb`, `bad` and `ovf` are 0; `out_adr` = 0; `out_dat` = 0.
- Latency: the `rx_stb` of CHK in cycle t gives `out_stb` (or `bad`/`ovf`) high in cycle t+1.
- `bad` and `ovf` are exactly one cycle wide. They are never both high for the same frame.
- A `rx_err` abort gives `bad` in the cycle after that `rx_stb`.
- The block accepts a byte every cycle, so it needs no input stall; `receive` has no back-pressure.
- Reset mid-frame discards the partial frame and any pending output. No pulse is emitted.

## Test plan

- Basic frame (BYTES=2):
  - Stimulus: A5 12 BE EF 43 with `out_rdy`=1.
  - Response: `out_stb` for one cycle, one cycle after the `43` strobe, with `out_adr`=8'h12 and `out_dat`=16'hBEEF. `bad`=0, `ovf`=0.
- Bad checksum:
  - Stimulus: A5 12 BE EF 44.
  - Response: no `out_stb`, and a single `bad` pulse one cycle after the `44` strobe. A following A5 34 00 01 35 yields `out_adr`=34 and `out_dat`=0001.
- Hunt and SYNC-as-data:
  - Stimulus: 00 FF 5A A5 A5 A5 A5 A5.
  - Response: exactly one frame with `out_adr`=A5 and `out_dat`=A5A5; the check is A5^A5^A5=A5. No `bad` is raised for the leading garbage.
- Framing error:
  - Stimulus: A5 12 BE, then EF with `rx_err`=1.
  - Response: `bad` pulses once, with no `out_stb`. A following full good frame decodes normally.
- Back-pressure:
  - Stimulus: hold `out_rdy`=0 and send two good frames, 12/BEEF then 34/0001.
  - Response: the first frame is held stable, and `ovf` pulses once after the second CHK.
  - Then raise `out_rdy` in the same cycle as the CHK strobe of a third frame 56/CAFE (CHK=56^CA^FE=62). Response: `out_stb` remains high and `out_dat` becomes CAFE.
- Reset mid-frame:
  - Stimulus: A5 12, assert `rst`, then BE EF 43.
  - Response: no output and no `bad`. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/frame_decode.sv
// frame_decode: hunts for SYNC, then assembles ADR + BYTES data bytes
// (big-endian) and checks an XOR checksum. Good frames go to a valid/ready
// output register. A frame that completes while that register is still
// occupied and not being accepted is dropped with an ovf pulse.
module frame_decode #(
  parameter int          BYTES = 2,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_stb,
  input  logic [7:0]           rx_dat,
  input  logic                 rx_err,
  output logic                 out_stb,
  input  logic                 out_rdy,
  output logic [7:0]           out_adr,
  output logic [8*BYTES-1:0]   out_dat,
  output logic                 bad,
  output logic                 ovf
);
  localparam int W = 8 * BYTES;

  typedef enum logic [1:0] {HUNT, ADDR, DATA, CHECK} state_t;

  state_t         state_q;
  logic [2:0]     cnt_q;
  logic [7:0]     adr_q;
  logic [W-1:0]   word_q;
  logic [7:0]     sum_q;
  logic           out_stb_q;
  logic [7:0]     out_adr_q;
  logic [W-1:0]   out_dat_q;
  logic           bad_q;
  logic           ovf_q;

  logic [W-1:0]   word_d;
  logic [7:0]     sum_d;

  // Next shadow word / running XOR when a data byte is absorbed.
  // The oldest byte falls off the top, so the first byte ends up in the MSBs.
  always_comb begin
    word_d = W'({word_q, rx_dat});
    sum_d  = sum_q ^ rx_dat;
  end

  // Frame FSM plus registered output port and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      adr_q     <= '0;
      word_q    <= '0;
      sum_q     <= '0;
      out_stb_q <= 1'b0;
      out_adr_q <= '0;
      out_dat_q <= '0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
      // A completion load below overrides this clear.
      if (out_stb_q && out_rdy) out_stb_q <= 1'b0;
      if (rx_stb) begin
        if (state_q != HUNT && rx_err) begin
          // Errored byte mid-frame: abandon it, never treat it as SYNC.
          bad_q   <= 1'b1;
          state_q <= HUNT;
        end else begin
          unique case (state_q)
            HUNT: begin
              if (!rx_err && rx_dat == SYNC) begin
                state_q <= ADDR;
                word_q  <= '0;
                sum_q   <= '0;
              end
            end
            ADDR: begin
              adr_q   <= rx_dat;
              sum_q   <= rx_dat;
              word_q  <= '0;
              cnt_q   <= '0;
              state_q <= DATA;
            end
            DATA: begin
              word_q <= word_d;
              sum_q  <= sum_d;
              cnt_q  <= cnt_q + 3'd1;
              if (cnt_q == 3'(BYTES - 1)) state_q <= CHECK;
            end
            CHECK: begin
              state_q <= HUNT;
              if (rx_dat != sum_q) begin
                bad_q <= 1'b1;
              end else if (!out_stb_q || out_rdy) begin
                out_stb_q <= 1'b1;
                out_adr_q <= adr_q;
                out_dat_q <= word_q;
              end else begin
                ovf_q <= 1'b1;
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
    end
  end

  assign out_stb = out_stb_q;
  assign out_adr = out_adr_q;
  assign out_dat = out_dat_q;
  assign bad     = bad_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_frame_decode.sv
// Scoreboard bench for frame_decode: the driver feeds bytes and a frame-level
// reference model pushes expected outputs; a monitor checks what appears.
module tb_frame_decode;
  localparam int         BYTES = 2;
  localparam int         W     = 8 * BYTES;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic         clk = 0, rst = 1;
  logic         rx_stb = 0, rx_err = 0, out_rdy = 0;
  logic [7:0]   rx_dat = 0;
  logic         out_stb, bad, ovf;
  logic [7:0]   out_adr;
  logic [W-1:0] out_dat;

  frame_decode #(.BYTES(BYTES), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_err(rx_err),
    .out_stb(out_stb), .out_rdy(out_rdy), .out_adr(out_adr), .out_dat(out_dat),
    .bad(bad), .ovf(ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] adr; logic [W-1:0] dat; int cyc; } frm_t;
  frm_t fq[$];
  int   bq[$], oq[$];
  int   npass = 0, ntot = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic unexp(string nm);
    ntot++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // ---- reference model: frame level, byte list + pending output flag ----
  bit         m_hunt = 1;
  logic [7:0] m_buf[$];
  bit         m_pend = 0;

  task automatic model(bit stb, logic [7:0] d, bit err, bit rdy, int stamp);
    bit xfer, comp;
    logic [7:0]   x;
    logic [W-1:0] w;
    frm_t f;
    xfer = m_pend && rdy;
    comp = 0;
    w = '0;
    if (stb) begin
      if (m_hunt) begin
        if (!err && d == SYNC) begin m_hunt = 0; m_buf.delete(); end
      end else if (err) begin
        bq.push_back(stamp); m_hunt = 1;
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == BYTES + 2) begin
          x = 0;
          for (int i = 0; i <= BYTES; i++) x ^= m_buf[i];
          for (int i = 1; i <= BYTES; i++) w = (w << 8) | W'(m_buf[i]);
          if (x == m_buf[BYTES+1]) comp = 1; else bq.push_back(stamp);
          m_hunt = 1;
        end
      end
    end
    if (comp) begin
      if (m_pend && !rdy) oq.push_back(stamp);
      else begin
        f.adr = m_buf[0]; f.dat = w; f.cyc = stamp;
        fq.push_back(f); m_pend = 1;
      end
    end else if (xfer) m_pend = 0;
  endtask

  // ---- driver ----
  task automatic cycle(bit stb, logic [7:0] d, bit err, bit rdy);
    @(posedge clk); #1;
    rx_stb = stb; rx_dat = d; rx_err = err; out_rdy = rdy;
    model(stb, d, err, rdy, cyc + 1);
  endtask

  task automatic send(logic [7:0] d, bit err = 0, bit rdy = 1);
    cycle(1, d, err, rdy);
  endtask

  task automatic idle(int n, bit rdy = 1);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; rx_stb = 0; rx_err = 0;
    m_hunt = 1; m_pend = 0; m_buf.delete(); fq.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // ---- monitor ----
  bit   prev_stb = 0, prev_xfer = 0;
  frm_t cur;
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 0; prev_xfer = 0;
    end else begin
      if (out_stb && (!prev_stb || prev_xfer)) begin
        if (fq.size() == 0) unexp("out_stb");
        else begin
          cur = fq.pop_front();
          chk("out_adr", 64'(out_adr), 64'(cur.adr));
          chk("out_dat", 64'(out_dat), 64'(cur.dat));
          chk("out_cyc", 64'(cyc), 64'(cur.cyc));
        end
      end else if (out_stb) begin
        chk("hold_adr", 64'(out_adr), 64'(cur.adr));
        chk("hold_dat", 64'(out_dat), 64'(cur.dat));
      end
      if (bad) begin
        if (bq.size() == 0) unexp("bad");
        else chk("bad_cyc", 64'(cyc), 64'(bq.pop_front()));
      end
      if (ovf) begin
        if (oq.size() == 0) unexp("ovf");
        else chk("ovf_cyc", 64'(cyc), 64'(oq.pop_front()));
      end
      prev_stb  = out_stb;
      prev_xfer = out_stb && out_rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---- stimulus ----
  initial begin
    logic [7:0]   a, c, b;
    logic [W-1:0] w;
    int           k, ep;

    #12;
    chk("rst_stb", 64'(out_stb), 0);
    chk("rst_bad", 64'(bad), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_adr", 64'(out_adr), 0);
    chk("rst_dat", 64'(out_dat), 0);
    @(posedge clk); #1; rst = 0;

    // basic frame
    send(8'hA5); send(8'h12); send(8'hBE); send(8'hEF); send(8'h43);
    idle(3);
    // bad checksum then good frame
    send(8'hA5); send(8'h12); send(8'hBE); send(8'hEF); send(8'h44);
    send(8'hA5); send(8'h34); send(8'h00); send(8'h01); send(8'h35);
    idle(3);
    // hunt garbage and SYNC-valued payload
    send(8'h00); send(8'hFF); send(8'h5A);
    for (int i = 0; i < 5; i++) send(8'hA5);
    idle(3);
    // framing error mid-frame, then good frame (with gaps)
    send(8'hA5); send(8'h12); send(8'hBE); send(8'hEF, 1);
    send(8'hA5); idle(2); send(8'h12); send(8'hBE); idle(1); send(8'hEF); send(8'h43);
    idle(3);
    // back-pressure: hold, overflow, then accept-and-reload in one cycle
    send(8'hA5, 0, 0); send(8'h12, 0, 0); send(8'hBE, 0, 0); send(8'hEF, 0, 0); send(8'h43, 0, 0);
    idle(2, 0);
    send(8'hA5, 0, 0); send(8'h34, 0, 0); send(8'h00, 0, 0); send(8'h01, 0, 0); send(8'h35, 0, 0);
    idle(2, 0);
    send(8'hA5, 0, 0); send(8'h56, 0, 0); send(8'hCA, 0, 0); send(8'hFE, 0, 0); send(8'h62, 0, 1);
    idle(3, 0);
    chk("bp_stb", 64'(out_stb), 1);
    chk("bp_dat", 64'(out_dat), 64'hCAFE);
    idle(2);
    // reset mid-frame
    send(8'hA5); send(8'h12);
    do_reset();
    send(8'hBE); send(8'hEF); send(8'h43);
    idle(2);
    send(8'hA5); send(8'h77); send(8'h12); send(8'h34); send(8'h77 ^ 8'h12 ^ 8'h34);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        b = 8'($urandom);
        cycle(1, b, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      end else begin
        a = 8'($urandom); w = W'($urandom);
        c = a;
        for (int i = 0; i < BYTES; i++) c ^= w[8*i +: 8];
        if (k == 1) c ^= 8'(1 << $urandom_range(0, 7));
        ep = (k == 2) ? $urandom_range(1, BYTES + 2) : -1;
        for (int i = 0; i < BYTES + 3; i++) begin
          if (i == 0)              b = SYNC;
          else if (i == 1)         b = a;
          else if (i <= BYTES + 1) b = w[8*(BYTES+1-i) +: 8];
          else                     b = c;
          cycle(1, b, i == ep, $urandom_range(0, 9) < 7);
          if ($urandom_range(0, 3) == 0) cycle(0, 8'h00, 0, $urandom_range(0, 9) < 7);
        end
      end
    end
    idle(10);
    chk("fq_empty", 64'(fq.size()), 0);
    chk("bq_empty", 64'(bq.size()), 0);
    chk("oq_empty", 64'(oq.size()), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
